// File: rtl/uart_pkg.sv
// Register map, STATUS bit positions, transmit FSM encoding and baud counter sizing
// shared by the memory-mapped UART transmitter.
package uart_pkg;

  localparam logic [2:0] OFF_TXDATA = 3'h0;
  localparam logic [2:0] OFF_STATUS = 3'h4;

  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_PARITY    = 4;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_e;

  // Bits needed to hold a baud counter that counts DIV-1 down to 0.
  function automatic int div_width(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through read (rd_dat valid alongside rd_en, zero latency).
// A write while full is refused unless a read frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_dat,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  logic [WIDTH-1:0] mem [DEPTH];
  ptr_t wr_ptr, rd_ptr;
  logic do_wr, do_rd;

  assign empty  = (count == '0);
  assign full   = (count == cnt_t'(DEPTH));
  assign do_rd  = rd_en && !empty;
  assign do_wr  = wr_en && (!full || do_rd);
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + ptr_t'(1);
      if (do_rd) rd_ptr <= rd_ptr + ptr_t'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter behind a TX FIFO; STATUS loads return one cycle after the address.
// Stores to a full FIFO are dropped and flagged in sticky STATUS.ovf; `UART_TX_PARITY_EN adds even parity.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int          CLK_HZ     = 50_000_000,
  parameter int          BAUD       = 115_200,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MemWrite_EN,
  input  logic [31:0] MemAddr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        rd_sel,
  output logic        uart_txd,
  output logic        irq_tx_empty
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int BW  = div_width(DIV);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  typedef logic [BW-1:0] baud_t;
  localparam baud_t DIV_M1 = baud_t'(DIV - 1);

  logic          hit, wr_txdata, rd_status, push, pop, ovf_set, ovf, busy;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_rd_dat;
  logic [31:0]   status;
  logic          unused_bits;

  tx_state_e  state, state_nxt;
  baud_t      baud_cnt, baud_nxt;
  logic [2:0] bit_cnt, bit_nxt;
  logic [7:0] shift_q, shift_nxt;
  logic       txd_q, txd_nxt, frame_done;
`ifdef UART_TX_PARITY_EN
  logic       par_q, par_nxt;
`endif

  assign hit       = (MemAddr[31:3] == BASE_ADDR[31:3]);
  assign wr_txdata = hit && (MemAddr[2] == OFF_TXDATA[2]);
  assign rd_status = hit && (MemAddr[2] == OFF_STATUS[2]) && (MemWrite_EN == 4'b0000);
  assign push      = wr_txdata && MemWrite_EN[0];
  // A pop in the same cycle makes room, so a push into a full FIFO is only lost without one.
  assign ovf_set   = push && fifo_full && !pop;
  assign busy      = (state != S_IDLE);

  assign uart_txd     = txd_q;
  assign irq_tx_empty = fifo_empty && !busy;
  assign unused_bits  = ^{WriteData[31:8], MemAddr[1:0]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (push),
    .wr_dat (WriteData[7:0]),
    .rd_en  (pop),
    .rd_dat (fifo_rd_dat),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    status                        = '0;
    status[ST_COUNT_LSB +: 8]     = 8'(fifo_count);
    status[ST_OVF]                = ovf;
    status[ST_EMPTY]              = fifo_empty;
    status[ST_FULL]               = fifo_full;
    status[ST_BUSY]               = busy;
`ifdef UART_TX_PARITY_EN
    status[ST_PARITY]             = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_sel   <= 1'b0;
      ReadData <= '0;
      ovf      <= 1'b0;
    end else begin
      rd_sel   <= hit;
      ReadData <= rd_status ? status : '0;
      if (ovf_set)        ovf <= 1'b1;
      else if (rd_status) ovf <= 1'b0;
    end
  end

  // txd is registered from next-state values so the line never glitches.
  always_comb begin
    state_nxt  = state;
    baud_nxt   = baud_cnt;
    bit_nxt    = bit_cnt;
    shift_nxt  = shift_q;
    txd_nxt    = txd_q;
    pop        = 1'b0;
    frame_done = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nxt    = par_q;
`endif
    case (state)
      S_IDLE: begin
        txd_nxt    = 1'b1;
        frame_done = 1'b1;
      end
      S_START: begin
        if (baud_cnt == '0) begin
          state_nxt = S_DATA;
          baud_nxt  = DIV_M1;
          bit_nxt   = 3'd0;
          txd_nxt   = shift_q[0];
        end else begin
          baud_nxt  = baud_cnt - baud_t'(1);
        end
      end
      S_DATA: begin
        if (baud_cnt == '0) begin
          baud_nxt  = DIV_M1;
          shift_nxt = {1'b0, shift_q[7:1]};
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = S_PARITY;
            txd_nxt   = par_q;
`else
            state_nxt = S_STOP;
            txd_nxt   = 1'b1;
`endif
          end else begin
            bit_nxt   = bit_cnt + 3'd1;
            txd_nxt   = shift_q[1];
          end
        end else begin
          baud_nxt  = baud_cnt - baud_t'(1);
        end
      end
      S_PARITY: begin
`ifdef UART_TX_PARITY_EN
        if (baud_cnt == '0) begin
          state_nxt = S_STOP;
          baud_nxt  = DIV_M1;
          txd_nxt   = 1'b1;
        end else begin
          baud_nxt  = baud_cnt - baud_t'(1);
        end
`else
        state_nxt = S_IDLE;
        txd_nxt   = 1'b1;
`endif
      end
      S_STOP: begin
        if (baud_cnt == '0) begin
          state_nxt  = S_IDLE;
          txd_nxt    = 1'b1;
          frame_done = 1'b1;
        end else begin
          baud_nxt   = baud_cnt - baud_t'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        txd_nxt   = 1'b1;
      end
    endcase

    // Reloading straight out of STOP gives back-to-back frames with no idle bit.
    if (frame_done && !fifo_empty) begin
      pop       = 1'b1;
      shift_nxt = fifo_rd_dat;
      baud_nxt  = DIV_M1;
      state_nxt = S_START;
      txd_nxt   = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_nxt   = ^fifo_rd_dat;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shift_q  <= shift_nxt;
      txd_q    <= txd_nxt;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_nxt;
`endif
    end
  end

endmodule
